// File: rtl/audio_stats_pkg.sv
// Shared types and defaults for the audio statistics monitor.
package audio_stats_pkg;

  localparam int SMPL_W_DEF  = 16;
  localparam int LOG_WIN_DEF = 10;

  typedef logic signed [SMPL_W_DEF-1:0] smpl_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // Sign change between consecutive samples; zero counts as non-negative.
  function automatic logic sign_chg(input logic prev_msb, input logic cur_msb);
    return prev_msb ^ cur_msb;
  endfunction

endpackage

// File: rtl/audio_stats_mon_if.sv
// Sample stream in, per-window statistics out.
interface audio_stats_mon_if #(
  parameter int SMPL_W  = 16,
  parameter int LOG_WIN = 10
);

  logic               smpl_vld;
  logic [SMPL_W-1:0]  lft_smpl;
  logic [SMPL_W-1:0]  rht_smpl;
  logic               clr;
  logic [SMPL_W-1:0]  lft_max;
  logic [SMPL_W-1:0]  lft_min;
  logic [SMPL_W-1:0]  rht_max;
  logic [SMPL_W-1:0]  rht_min;
  logic [LOG_WIN-1:0] lft_xing;
  logic [LOG_WIN-1:0] rht_xing;
  logic [SMPL_W-1:0]  lft_avg;
  logic [SMPL_W-1:0]  rht_avg;
  logic               stats_vld;

  modport master (
    output smpl_vld, lft_smpl, rht_smpl, clr,
    input  lft_max, lft_min, rht_max, rht_min,
    input  lft_xing, rht_xing, lft_avg, rht_avg, stats_vld
  );

  modport slave (
    input  smpl_vld, lft_smpl, rht_smpl, clr,
    output lft_max, lft_min, rht_max, rht_min,
    output lft_xing, rht_xing, lft_avg, rht_avg, stats_vld
  );

endinterface

// File: rtl/audio_stats_mon_chnl_stats.sv
// One channel's window accumulators (max/min/sum/crossings) and published results.
module chnl_stats
  import audio_stats_pkg::*;
#(
  parameter int LOG_WIN = LOG_WIN_DEF,
  parameter int SMPL_W  = SMPL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_i,
  input  logic                     acc_i,
  input  logic                     pub_i,
  input  logic signed [SMPL_W-1:0] smpl_i,
  output logic signed [SMPL_W-1:0] max_o,
  output logic signed [SMPL_W-1:0] min_o,
  output logic [LOG_WIN-1:0]       xing_o,
  output logic signed [SMPL_W-1:0] avg_o
);

  localparam int SUM_W = SMPL_W + LOG_WIN;

  logic signed [SMPL_W-1:0] max_q, max_d;
  logic signed [SMPL_W-1:0] min_q, min_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG_WIN-1:0]       xing_q, xing_d;
  logic signed [SMPL_W-1:0] prev_q, prev_d;
  logic signed [SUM_W-1:0]  smpl_ext_s;
  logic signed [SMPL_W-1:0] avg_s;

  assign smpl_ext_s = $signed({{LOG_WIN{smpl_i[SMPL_W-1]}}, smpl_i});
  // Floor division by the window length; always fits back into a sample.
  assign avg_s      = SMPL_W'(sum_q >>> LOG_WIN);

  // Next-state for the running accumulators.
  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    sum_d  = sum_q;
    xing_d = xing_q;
    prev_d = prev_q;
    if (init_i) begin
      max_d  = smpl_i;
      min_d  = smpl_i;
      sum_d  = smpl_ext_s;
      xing_d = {LOG_WIN{1'b0}};
      prev_d = smpl_i;
    end else if (acc_i) begin
      if (smpl_i > max_q) begin
        max_d = smpl_i;
      end else begin
        max_d = max_q;
      end
      if (smpl_i < min_q) begin
        min_d = smpl_i;
      end else begin
        min_d = min_q;
      end
      sum_d  = sum_q + smpl_ext_s;
      xing_d = xing_q + LOG_WIN'(sign_chg(prev_q[SMPL_W-1], smpl_i[SMPL_W-1]));
      prev_d = smpl_i;
    end else begin
      prev_d = prev_q;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q  <= '0;
      min_q  <= '0;
      sum_q  <= '0;
      xing_q <= '0;
      prev_q <= '0;
    end else begin
      max_q  <= max_d;
      min_q  <= min_d;
      sum_q  <= sum_d;
      xing_q <= xing_d;
      prev_q <= prev_d;
    end
  end

  // Published results hold until the next completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_o  <= '0;
      min_o  <= '0;
      xing_o <= '0;
      avg_o  <= '0;
    end else if (pub_i) begin
      max_o  <= max_q;
      min_o  <= min_q;
      xing_o <= xing_q;
      avg_o  <= avg_s;
    end else begin
      max_o  <= max_o;
      min_o  <= min_o;
      xing_o <= xing_o;
      avg_o  <= avg_o;
    end
  end

endmodule

// File: rtl/audio_stats_mon.sv
// Windowed per-channel audio statistics: shared sequencing FSM plus two channel units.
module audio_stats_mon
  import audio_stats_pkg::*;
#(
  parameter int LOG_WIN = LOG_WIN_DEF,
  parameter int SMPL_W  = SMPL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  audio_stats_mon_if.slave bus
);

  localparam int             CNT_W    = LOG_WIN + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG_WIN) - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stats_vld_q;
  logic             accept_s;
  logic             init_s;
  logic             acc_s;
  logic             pub_s;

  assign accept_s = bus.smpl_vld & ~bus.clr;

  // Decode channel controls; a sample in PUBLISH opens the next window.
  always_comb begin
    init_s = 1'b0;
    acc_s  = 1'b0;
    pub_s  = 1'b0;
    case (state_q)
      IDLE:    init_s = accept_s;
      ACCUM:   acc_s  = accept_s;
      PUBLISH: begin
        pub_s  = ~bus.clr;
        init_s = accept_s;
      end
      default: begin
        init_s = 1'b0;
        acc_s  = 1'b0;
        pub_s  = 1'b0;
      end
    endcase
  end

  // Window sequencing FSM with sample counter and registered valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stats_vld_q <= 1'b0;
    end else if (bus.clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stats_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stats_vld_q <= 1'b0;
          if (bus.smpl_vld) begin
            state_q <= ACCUM;
            cnt_q   <= CNT_W'(1);
          end
        end
        ACCUM: begin
          stats_vld_q <= 1'b0;
          if (bus.smpl_vld) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= PUBLISH;
            end
          end
        end
        PUBLISH: begin
          stats_vld_q <= 1'b1;
          if (bus.smpl_vld) begin
            state_q <= ACCUM;
            cnt_q   <= CNT_W'(1);
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          stats_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stats_vld = stats_vld_q;

  chnl_stats #(.LOG_WIN(LOG_WIN), .SMPL_W(SMPL_W)) u_lft (
    .clk    (clk),
    .rst    (rst),
    .init_i (init_s),
    .acc_i  (acc_s),
    .pub_i  (pub_s),
    .smpl_i ($signed(bus.lft_smpl)),
    .max_o  (bus.lft_max),
    .min_o  (bus.lft_min),
    .xing_o (bus.lft_xing),
    .avg_o  (bus.lft_avg)
  );

  chnl_stats #(.LOG_WIN(LOG_WIN), .SMPL_W(SMPL_W)) u_rht (
    .clk    (clk),
    .rst    (rst),
    .init_i (init_s),
    .acc_i  (acc_s),
    .pub_i  (pub_s),
    .smpl_i ($signed(bus.rht_smpl)),
    .max_o  (bus.rht_max),
    .min_o  (bus.rht_min),
    .xing_o (bus.rht_xing),
    .avg_o  (bus.rht_avg)
  );

endmodule

// File: tb/tb_audio_stats_mon.sv
// Directed bench for audio_stats_mon with an 8-sample window.
module tb_audio_stats_mon;
  import audio_stats_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  audio_stats_mon_if #(.SMPL_W(16), .LOG_WIN(3)) mon_if ();

  audio_stats_mon #(.LOG_WIN(3), .SMPL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  smpl_t l1 [8] = '{16'sd100, -16'sd50, 16'sd200, -16'sd300, 16'sd0, 16'sd5, 16'sd5, -16'sd1};
  smpl_t r1 [8] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
  smpl_t mn [8] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
  smpl_t alt[8] = '{16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh8000};
  smpl_t sv [8] = '{16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7};
  smpl_t l6 [8] = '{-16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4};
  smpl_t r6 [8] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd60, 16'sd70, 16'sd80};

  // Drives one strobe; returns #1 after the accepting edge.
  task automatic strobe(input smpl_t l, input smpl_t r);
    @(negedge clk);
    mon_if.smpl_vld = 1'b1;
    mon_if.lft_smpl = l;
    mon_if.rht_smpl = r;
    @(posedge clk);
    #1;
    mon_if.smpl_vld = 1'b0;
  endtask

  task automatic send_window(input smpl_t l[8], input smpl_t r[8], input int gap);
    for (int i = 0; i < 8; i++) begin
      strobe(l[i], r[i]);
      if (i < 7) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mon_if.smpl_vld = 1'b1;
    mon_if.clr = 1'b0;
    mon_if.lft_smpl = 16'sd1234;
    mon_if.rht_smpl = 16'sd4321;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %0b want 0", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'd0) begin n_err++; $display("FAIL rst_lmax got %0d want 0", mon_if.lft_max); end
    n_cmp++; if (mon_if.rht_avg !== 16'd0) begin n_err++; $display("FAIL rst_ravg got %0d want 0", mon_if.rht_avg); end
    n_cmp++; if (mon_if.lft_xing !== 3'd0) begin n_err++; $display("FAIL rst_lxing got %0d want 0", mon_if.lft_xing); end
    mon_if.smpl_vld = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_rate();
    send_window(l1, r1, 0);
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s1_early got %0b want 0", mon_if.stats_vld); end
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s1_vld got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sd200) begin n_err++; $display("FAIL s1_lmax got %0d want 200", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_min !== -16'sd300) begin n_err++; $display("FAIL s1_lmin got %0d want -300", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.lft_xing !== 3'd5) begin n_err++; $display("FAIL s1_lxing got %0d want 5", mon_if.lft_xing); end
    n_cmp++; if (mon_if.lft_avg !== -16'sd6) begin n_err++; $display("FAIL s1_lavg got %0d want -6", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_max !== 16'sh7FFF) begin n_err++; $display("FAIL s1_rmax got %0d want 32767", $signed(mon_if.rht_max)); end
    n_cmp++; if (mon_if.rht_min !== 16'sh7FFF) begin n_err++; $display("FAIL s1_rmin got %0d want 32767", $signed(mon_if.rht_min)); end
    n_cmp++; if (mon_if.rht_xing !== 3'd0) begin n_err++; $display("FAIL s1_rxing got %0d want 0", mon_if.rht_xing); end
    n_cmp++; if (mon_if.rht_avg !== 16'sh7FFF) begin n_err++; $display("FAIL s1_ravg got %0d want 32767", $signed(mon_if.rht_avg)); end
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s1_pulse_len got %0b want 0", mon_if.stats_vld); end
  endtask

  task automatic test_gaps();
    send_window(l1, r1, 4);
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s2_early got %0b want 0", mon_if.stats_vld); end
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s2_vld got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sd200) begin n_err++; $display("FAIL s2_lmax got %0d want 200", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_min !== -16'sd300) begin n_err++; $display("FAIL s2_lmin got %0d want -300", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.lft_xing !== 3'd5) begin n_err++; $display("FAIL s2_lxing got %0d want 5", mon_if.lft_xing); end
    n_cmp++; if (mon_if.lft_avg !== -16'sd6) begin n_err++; $display("FAIL s2_lavg got %0d want -6", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_avg !== 16'sh7FFF) begin n_err++; $display("FAIL s2_ravg got %0d want 32767", $signed(mon_if.rht_avg)); end
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s2_pulse_len got %0b want 0", mon_if.stats_vld); end
  endtask

  task automatic test_extremes();
    send_window(mn, mn, 0);
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s3a_vld got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sh8000) begin n_err++; $display("FAIL s3a_lmax got %0d want -32768", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.rht_min !== 16'sh8000) begin n_err++; $display("FAIL s3a_rmin got %0d want -32768", $signed(mon_if.rht_min)); end
    n_cmp++; if (mon_if.lft_avg !== 16'sh8000) begin n_err++; $display("FAIL s3a_lavg got %0d want -32768", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_xing !== 3'd0) begin n_err++; $display("FAIL s3a_rxing got %0d want 0", mon_if.rht_xing); end
    @(posedge clk); #1;
    send_window(alt, alt, 1);
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s3b_vld got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_xing !== 3'd7) begin n_err++; $display("FAIL s3b_lxing got %0d want 7", mon_if.lft_xing); end
    n_cmp++; if (mon_if.rht_xing !== 3'd7) begin n_err++; $display("FAIL s3b_rxing got %0d want 7", mon_if.rht_xing); end
    n_cmp++; if (mon_if.lft_avg !== -16'sd1) begin n_err++; $display("FAIL s3b_lavg got %0d want -1", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.lft_max !== 16'sh7FFF) begin n_err++; $display("FAIL s3b_lmax got %0d want 32767", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.rht_min !== 16'sh8000) begin n_err++; $display("FAIL s3b_rmin got %0d want -32768", $signed(mon_if.rht_min)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      strobe(16'(i), 16'(i));
      if (mon_if.stats_vld === 1'b1) pulses++;
      if (i == 8) begin
        n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s4_early got %0b want 0", mon_if.stats_vld); end
      end
      if (i == 9) begin
        n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s4_vld1 got %0b want 1", mon_if.stats_vld); end
        n_cmp++; if (mon_if.lft_max !== 16'sd8) begin n_err++; $display("FAIL s4_lmax1 got %0d want 8", $signed(mon_if.lft_max)); end
        n_cmp++; if (mon_if.lft_min !== 16'sd1) begin n_err++; $display("FAIL s4_lmin1 got %0d want 1", $signed(mon_if.lft_min)); end
        n_cmp++; if (mon_if.lft_avg !== 16'sd4) begin n_err++; $display("FAIL s4_lavg1 got %0d want 4", $signed(mon_if.lft_avg)); end
      end
    end
    @(posedge clk); #1;
    if (mon_if.stats_vld === 1'b1) pulses++;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s4_vld2 got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_min !== 16'sd9) begin n_err++; $display("FAIL s4_lmin2 got %0d want 9", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.lft_max !== 16'sd16) begin n_err++; $display("FAIL s4_lmax2 got %0d want 16", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_avg !== 16'sd12) begin n_err++; $display("FAIL s4_lavg2 got %0d want 12", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_avg !== 16'sd12) begin n_err++; $display("FAIL s4_ravg2 got %0d want 12", $signed(mon_if.rht_avg)); end
    n_cmp++; if (mon_if.lft_xing !== 3'd0) begin n_err++; $display("FAIL s4_lxing2 got %0d want 0", mon_if.lft_xing); end
    n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL s4_pulses got %0d want 2", pulses); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    strobe(16'sd1000, -16'sd1000);
    strobe(-16'sd1000, 16'sd1000);
    strobe(16'sd2000, -16'sd2000);
    strobe(-16'sd2000, 16'sd2000);
    strobe(16'sd500, -16'sd500);
    // clr coinciding with a strobe must discard that sample too
    @(negedge clk);
    mon_if.clr = 1'b1;
    mon_if.smpl_vld = 1'b1;
    mon_if.lft_smpl = 16'sd30000;
    mon_if.rht_smpl = -16'sd30000;
    @(posedge clk); #1;
    mon_if.clr = 1'b0;
    mon_if.smpl_vld = 1'b0;
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s5_clr_vld got %0b want 0", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sd16) begin n_err++; $display("FAIL s5_hold got %0d want 16", $signed(mon_if.lft_max)); end
    send_window(sv, sv, 0);
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s5_early got %0b want 0", mon_if.stats_vld); end
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s5_vld got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sd7) begin n_err++; $display("FAIL s5_lmax got %0d want 7", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_min !== 16'sd7) begin n_err++; $display("FAIL s5_lmin got %0d want 7", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.lft_avg !== 16'sd7) begin n_err++; $display("FAIL s5_lavg got %0d want 7", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_min !== 16'sd7) begin n_err++; $display("FAIL s5_rmin got %0d want 7", $signed(mon_if.rht_min)); end
    n_cmp++; if (mon_if.rht_avg !== 16'sd7) begin n_err++; $display("FAIL s5_ravg got %0d want 7", $signed(mon_if.rht_avg)); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    strobe(16'sd11, 16'sd22);
    strobe(-16'sd11, -16'sd22);
    strobe(16'sd11, 16'sd22);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b0) begin n_err++; $display("FAIL s6_vld got %0b want 0", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'd0) begin n_err++; $display("FAIL s6_lmax got %0d want 0", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_min !== 16'd0) begin n_err++; $display("FAIL s6_lmin got %0d want 0", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.rht_max !== 16'd0) begin n_err++; $display("FAIL s6_rmax got %0d want 0", $signed(mon_if.rht_max)); end
    n_cmp++; if (mon_if.lft_avg !== 16'd0) begin n_err++; $display("FAIL s6_lavg got %0d want 0", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_avg !== 16'd0) begin n_err++; $display("FAIL s6_ravg got %0d want 0", $signed(mon_if.rht_avg)); end
    rst = 1'b0;
    send_window(l6, r6, 1);
    @(posedge clk); #1;
    n_cmp++; if (mon_if.stats_vld !== 1'b1) begin n_err++; $display("FAIL s6_vld2 got %0b want 1", mon_if.stats_vld); end
    n_cmp++; if (mon_if.lft_max !== 16'sd4) begin n_err++; $display("FAIL s6_lmax2 got %0d want 4", $signed(mon_if.lft_max)); end
    n_cmp++; if (mon_if.lft_min !== -16'sd3) begin n_err++; $display("FAIL s6_lmin2 got %0d want -3", $signed(mon_if.lft_min)); end
    n_cmp++; if (mon_if.lft_xing !== 3'd1) begin n_err++; $display("FAIL s6_lxing got %0d want 1", mon_if.lft_xing); end
    n_cmp++; if (mon_if.lft_avg !== 16'sd0) begin n_err++; $display("FAIL s6_lavg2 got %0d want 0", $signed(mon_if.lft_avg)); end
    n_cmp++; if (mon_if.rht_max !== 16'sd80) begin n_err++; $display("FAIL s6_rmax2 got %0d want 80", $signed(mon_if.rht_max)); end
    n_cmp++; if (mon_if.rht_min !== 16'sd10) begin n_err++; $display("FAIL s6_rmin2 got %0d want 10", $signed(mon_if.rht_min)); end
    n_cmp++; if (mon_if.rht_avg !== 16'sd45) begin n_err++; $display("FAIL s6_ravg2 got %0d want 45", $signed(mon_if.rht_avg)); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_rate();
    test_gaps();
    test_extremes();
    test_back_to_back();
    test_clr();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
